// File: rtl/scope_trigger_capture_if.sv
// Sample stream, trigger setup and readout bundle for scope_trigger_capture.
// master = producer/reader side, slave = capture block.
interface scope_trigger_capture_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 9
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] trig_level;
    logic              trig_falling;
    logic              arm;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              trig_forced;

    modport master (
        output sample_valid, sample, trig_level, trig_falling, arm, rd_addr,
        input  rd_data, busy, done, trig_forced
    );

    modport slave (
        input  sample_valid, sample, trig_level, trig_falling, arm, rd_addr,
        output rd_data, busy, done, trig_forced
    );
endinterface

// File: rtl/scope_trigger_capture.sv
// Edge-triggered pre/post window capture into a circular sample RAM.
// Define AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT idle samples.
module scope_trigger_capture #(
    parameter int DATA_W       = 14,
    parameter int ADDR_W       = 9,
    parameter int PRETRIG      = 128,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    scope_trigger_capture_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW_A  = ADDR_W + 1;
    localparam int CW_T  = $clog2(AUTO_TIMEOUT + 1);
    localparam int CNT_W = (CW_A > CW_T) ? CW_A : CW_T;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRETRIG - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(DEPTH - PRETRIG - 2);

    typedef enum logic [2:0] {
        IDLE, PREFILL, WAIT_TRIG, POST, DONE
    } state_t;

    state_t state, next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] start;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rd_q;
    logic signed [DATA_W-1:0] prev;
    logic signed [DATA_W-1:0] smp;
    logic signed [DATA_W-1:0] lvl;
    logic prev_ok;
    logic active;
    logic hit;
    logic we;
    logic cnt_clr;
    logic cnt_inc;
    logic take;

`ifdef AUTO_TRIG_EN
    localparam logic [CNT_W-1:0] TMO = CNT_W'(AUTO_TIMEOUT);
    logic force_set;
    logic forced_r;
`endif

    assign smp    = $signed(bus.sample);
    assign lvl    = $signed(bus.trig_level);
    assign active = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);

    always_comb begin
        hit = 1'b0;
        if (prev_ok) begin
            if (bus.trig_falling)
                hit = (prev > lvl) && (smp <= lvl);
            else
                hit = (prev < lvl) && (smp >= lvl);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next    = state;
        we      = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        take    = 1'b0;
`ifdef AUTO_TRIG_EN
        force_set = 1'b0;
`endif
        if (bus.arm) begin
            next    = PREFILL;
            cnt_clr = 1'b1;
        end else if (bus.sample_valid && active) begin
            we = 1'b1;
            unique case (state)
                PREFILL: begin
                    cnt_inc = 1'b1;
                    if (cnt == PRE_LAST) begin
                        next    = WAIT_TRIG;
                        cnt_clr = 1'b1;
                    end
                end
                WAIT_TRIG: begin
                    if (hit) begin
                        take    = 1'b1;
                        next    = POST;
                        cnt_clr = 1'b1;
                    end
`ifdef AUTO_TRIG_EN
                    else if (cnt == TMO) begin
                        take      = 1'b1;
                        force_set = 1'b1;
                        next      = POST;
                        cnt_clr   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
`endif
                end
                POST: begin
                    cnt_inc = 1'b1;
                    if (cnt == POST_LAST) begin
                        next    = DONE;
                        cnt_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp      <= '0;
            start   <= '0;
            cnt     <= '0;
            prev    <= '0;
            prev_ok <= 1'b0;
            rd_q    <= '0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (bus.arm) begin
                prev_ok <= 1'b0;
            end else if (we) begin
                wp      <= wp + 1'b1;
                prev    <= smp;
                prev_ok <= 1'b1;
            end
            // wp still addresses the trigger sample in this cycle
            if (take) start <= wp - ADDR_W'(PRETRIG);
            rd_q <= mem[start + bus.rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wp] <= bus.sample;
    end

`ifdef AUTO_TRIG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            forced_r <= 1'b0;
        else if (bus.arm)   forced_r <= 1'b0;
        else if (force_set) forced_r <= 1'b1;
    end

    assign bus.trig_forced = forced_r && (state == DONE);
`else
    assign bus.trig_forced = 1'b0;
`endif

    assign bus.rd_data = rd_q;
    assign bus.busy    = active;
    assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed + randomized capture scenarios against a queue-based window model.
// Build with AUTO_TRIG_EN defined to exercise the forced trigger.
module tb_scope_trigger_capture;
    localparam int DATA_W       = 14;
    localparam int ADDR_W       = 4;
    localparam int DEPTH        = 16;
    localparam int PRETRIG      = 4;
    localparam int AUTO_TIMEOUT = 8;
`ifdef AUTO_TRIG_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scope_trigger_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    scope_trigger_capture #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .PRETRIG(PRETRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: every sample accepted since the last arm, plus trigger index.
    int q[$];
    int m_trig   = -1;
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_forced = 1'b0;
    int m_lvl    = 0;
    bit m_fall   = 1'b0;

    task automatic chk(string tag, logic signed [31:0] obs,
                       logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic check_status(string tag);
        chk({tag, "_busy"}, bus.busy, m_active);
        chk({tag, "_done"}, bus.done, m_done);
        chk({tag, "_forced"}, bus.trig_forced, m_done && m_forced);
    endtask

    task automatic set_trig(int lvl, bit fall);
        bus.trig_level   = 14'(lvl);
        bus.trig_falling = fall;
        m_lvl  = lvl;
        m_fall = fall;
    endtask

    task automatic do_arm(bit with_sample);
        @(posedge clk);
        #1;
        bus.arm          = 1'b1;
        bus.sample_valid = with_sample;
        bus.sample       = 14'(50);
        @(posedge clk);
        #1;
        bus.arm          = 1'b0;
        bus.sample_valid = 1'b0;
        q.delete();
        m_trig   = -1;
        m_active = 1'b1;
        m_done   = 1'b0;
        m_forced = 1'b0;
        check_status("arm");
    endtask

    task automatic send(int v);
        int n;
        bit hit;
        @(posedge clk);
        #1;
        bus.sample       = 14'(v);
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        if (m_active) begin
            q.push_back(v);
            n = q.size() - 1;
            if (m_trig < 0) begin
                if (n >= PRETRIG) begin
                    if (m_fall) hit = (q[n-1] > m_lvl) && (v <= m_lvl);
                    else        hit = (q[n-1] < m_lvl) && (v >= m_lvl);
                    if (hit) begin
                        m_trig = n;
                    end else if (AUTO && n == PRETRIG + AUTO_TIMEOUT) begin
                        m_trig   = n;
                        m_forced = 1'b1;
                    end
                end
            end else if (n == m_trig + DEPTH - PRETRIG - 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        check_status("smp");
        @(posedge clk);
    endtask

    task automatic rd_check(string tag, int idx, int exp);
        @(posedge clk);
        #1;
        bus.rd_addr = 4'(idx);
        @(posedge clk);
        #1;
        chk(tag, $signed(bus.rd_data), exp);
    endtask

    task automatic readout(string tag);
        chk({tag, "_done"}, bus.done, 1);
        if (m_done) begin
            for (int i = 0; i < DEPTH; i++)
                rd_check(tag, i, q[m_trig - PRETRIG + i]);
        end
    endtask

    task automatic rand_capture(string tag);
        int lvl;
        lvl = int'($urandom_range(20)) - 10;
        set_trig(lvl, 1'($urandom_range(1)));
        do_arm(1'b0);
        for (int k = 0; k < 300 && !m_done; k++)
            send(int'($urandom_range(60)) - 30);
        readout(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_seq[15];
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.arm          = 1'b0;
        bus.rd_addr      = '0;
        set_trig(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        chk("reset_rd", $signed(bus.rd_data), 0);
        rst = 1'b0;

        // rising ramp through zero
        set_trig(0, 1'b0);
        do_arm(1'b0);
        for (int v = -20; v <= 40; v++) send(v);
        readout("ramp_rd");
        rd_check("ramp_rd0", 0, -4);
        rd_check("ramp_rd4", 4, 0);
        rd_check("ramp_rd15", 15, 11);

        // falling edge
        fall_seq = '{9, 9, 9, 9, 5, 3, 1, -1, -3, -5, -7, -9, -11, -13, -15};
        set_trig(0, 1'b1);
        do_arm(1'b0);
        foreach (fall_seq[i]) send(fall_seq[i]);
        for (int v = -17; v >= -23; v -= 2) send(v);
        readout("fall_rd");
        rd_check("fall_rd4", 4, -1);

        // flat input, no edge
        set_trig(0, 1'b0);
        do_arm(1'b0);
`ifdef AUTO_TRIG_EN
        for (int k = 0; k < 40 && !m_done; k++) send(100);
        chk("flat_forced", bus.trig_forced, 1);
        readout("flat_rd");
`else
        for (int k = 0; k < 1000; k++) send(100);
        chk("flat_busy", bus.busy, 1);
        chk("flat_done", bus.done, 0);
`endif

        // arm mid-POST, arm together with a sample, fresh capture
        set_trig(0, 1'b0);
        do_arm(1'b0);
        for (int v = -10; v <= 3; v++) send(v);
        do_arm(1'b1);
        for (int v = -6; v <= 20; v++) send(v);
        readout("rearm_rd");
        rd_check("rearm_rd0", 0, -4);
        rd_check("rearm_rd4", 4, 0);

        // back-to-back random captures, write pointer wraps repeatedly
        rand_capture("rand0_rd");
        rand_capture("rand1_rd");
        rand_capture("rand2_rd");

        // asynchronous reset in WAIT_TRIG
        set_trig(0, 1'b0);
        do_arm(1'b0);
        for (int k = 0; k < 6; k++) send(100);
        chk("wait_busy", bus.busy, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_forced = 1'b0;
        check_status("async_rst");
        chk("async_rst_rd", $signed(bus.rd_data), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        check_status("post_rst");

        set_trig(0, 1'b0);
        do_arm(1'b0);
        for (int v = -12; v <= 15; v++) send(v);
        readout("after_rst_rd");
        rd_check("after_rst_rd4", 4, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Downstream consumer of the ADC front-end.
- Takes 14-bit signed conversion results with a one-cycle valid strobe and detects a level/edge trigger.
- Stores a pre/post-trigger window in a circular sample RAM and presents it to the display/readout logic in time order, oldest sample first.

Parameters:
- DATA_W, 14, sample width (two's complement).
- ADDR_W, 9, buffer address width; DEPTH = 2**ADDR_W.
- PRETRIG, 128, samples kept before the trigger; legal range 1..DEPTH-2.
- AUTO_TIMEOUT, 4096, valid samples in WAIT_TRIG before a forced trigger (AUTO_TRIG_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample_valid  in  1  one-cycle strobe, new sample present
- sample  in  DATA_W  signed sample
- trig_level  in  DATA_W  signed trigger threshold
- trig_falling  in  1  0 = rising edge, 1 = falling edge
- arm  in  1  one-cycle pulse, starts or restarts a capture
- rd_addr  in  ADDR_W  readout index, 0 = oldest sample of window
- rd_data  out  DATA_W  sample at rd_addr, 1-cycle latency
- busy  out  1  capture in progress
- done  out  1  window complete, held until next arm
- trig_forced  out  1  window was closed by auto-trigger

Behaviour:
- Reset values: all outputs 0, state IDLE, write pointer 0, counters 0, prev-sample-valid flag 0. RAM contents undefined.
- Reset asserted mid-capture aborts to IDLE; done stays 0.
- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE. busy=1 in PREFILL, WAIT_TRIG and POST.
- arm in any state:
  - go to PREFILL; clear counters, prev-valid flag, done and trig_forced.
  - Write pointer is not reset.
  - A sample_valid in the same cycle is discarded (arm wins).
- Every sample_valid in PREFILL, WAIT_TRIG or POST:
  - RAM[wp] <= sample; wp <= wp+1 mod DEPTH (wraps silently).
  - prev <= sample; prev-valid flag set.
- PREFILL: count stored samples; after the PRETRIG-th store, go to WAIT_TRIG.
- WAIT_TRIG, trigger condition on a valid sample, evaluated with prev-valid flag = 1:
  - Rising: prev < trig_level and sample >= trig_level (signed compare).
  - Falling: prev > trig_level and sample <= trig_level.
  - First sample after arm never triggers. Samples stored in WAIT_TRIG keep overwriting the oldest entries, so the buffer always holds the latest pre-trigger history.
- On trigger:
  - The triggering sample is stored.
  - Latch start = (wp_of_trigger_sample - PRETRIG) mod DEPTH.
  - Go to POST with post count 0.
- POST: store DEPTH-PRETRIG-1 further samples. On the last one go to DONE and set done=1 in the following cycle.
- Resulting window: trigger sample at readout index PRETRIG.
- DONE: no RAM writes; busy=0; done=1 until arm or rst.
- Readout:
  - Physical address = (start + rd_addr) mod DEPTH.
  - rd_data registered, valid one clk after rd_addr.
  - Reads are legal in any state; contents are only meaningful while done=1.
- trig_level and trig_falling are sampled live every cycle; they are not latched at arm.
- sample_valid in IDLE or DONE is ignored.

Optional Feature:
- Macro AUTO_TRIG_EN.
- Defined:
  - Counter counts valid samples in WAIT_TRIG and clears on entry to WAIT_TRIG.
  - When it reaches AUTO_TIMEOUT, the next valid sample is treated as the trigger, even if no edge is present, and trig_forced is set with done.
  - A real edge on that same sample has priority, and trig_forced stays 0.
- Undefined:
  - No counter.
  - WAIT_TRIG waits indefinitely.
  - trig_forced is tied to 0.

Test Plan (bench overrides DEPTH=16 via ADDR_W=4, PRETRIG=4, AUTO_TIMEOUT=8):
- Ramp test: rst 2 cycles, arm, feed ramp -20..+40 step 1 every 3rd clk, trig_level=0, rising.
  - Trigger on sample 0.
  - done after 11 more samples.
  - rd_addr 0..15 returns -4..11; busy drops the same cycle done rises.
- Falling edge: feed +5,+3,+1,-1,-3, trig_level=0, trig_falling=1.
  - Trigger on -1 (prev +1 > 0); rd_addr 4 returns -1.
- Flat input: constant 100, trig_level=0.
  - With AUTO_TRIG_EN: forced trigger on the 9th WAIT_TRIG sample; done=1, trig_forced=1.
  - Without: busy stays 1 for 1000 samples.
- Arm restart: arm mid-POST after 3 post samples, then feed a ramp.
  - Full new PREFILL required.
  - done only after a fresh trigger; window consistent with the second trigger.
  - An arm coinciding with sample_valid drops that sample.
- Wrap and reset: run 3 captures back-to-back so wp wraps; the third window still reads in time order.
  - Assert rst mid-WAIT_TRIG: all outputs 0 immediately, asynchronous; next arm works normally.
